// File: rtl/ieee_div16.sv
// ieee_div16: sequential IEEE-754 binary16 divider, quotient = float_a / float_b.
//
// Mantissas are divided by radix-2 restoring division, one quotient bit per clock.
// The result is truncated, not rounded. Subnormal operands are flushed to zero.
// Exponent field 31 is not decoded as NaN/Inf; it is treated as a normal value.
// A divisor of zero returns signed infinity with div_by_zero set. A zero dividend
// returns +0. Both special cases finish in a single cycle.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset; abandons any operation in progress
//   in_valid     operands presented on float_a / float_b
//   in_ready     idle and able to accept operands
//   float_a      dividend, binary16
//   float_b      divisor, binary16
//   out_valid    quotient / div_by_zero valid; held until out_ready
//   out_ready    consumer takes the result
//   quotient     result, binary16
//   div_by_zero  divisor was zero (qualifies quotient)

module ieee_div16 #(
  // Quotient bits produced; fixed by the binary16 format
  parameter int unsigned QBits = 12,
  // Exponent bias
  parameter int unsigned Bias  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] float_a,
  input  logic [15:0] float_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StNorm,
    StDone
  } state_e;

  localparam logic [3:0] LastStep = 4'(QBits - 1);
  localparam logic [6:0] BiasExp  = 7'(Bias);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;

  logic        sign_q, sign_d;
  logic [4:0]  ea_q, ea_d;
  logic [4:0]  eb_q, eb_d;
  logic [10:0] divisor_q, divisor_d;
  logic [11:0] rem_q, rem_d;
  logic [11:0] q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] quot_q, quot_d;
  logic        dbz_q, dbz_d;

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic a_zero;
  logic b_zero;
  logic sign_in;

  assign accept  = in_valid && (state_q == StIdle);
  // Exponent field 0 covers both zero and subnormals, which are flushed
  assign a_zero  = (float_a[14:10] == 5'd0);
  assign b_zero  = (float_b[14:10] == 5'd0);
  assign sign_in = float_a[15] ^ float_b[15];

  // ---------------------------------------------------------------------------
  // Divide step
  // ---------------------------------------------------------------------------
  // One extra bit so that the sign of the trial subtraction is visible.
  logic [12:0] trial;
  logic        trial_ok;

  assign trial    = {1'b0, rem_q} - {2'b00, divisor_q};
  assign trial_ok = ~trial[12];

  // ---------------------------------------------------------------------------
  // Normalisation
  // ---------------------------------------------------------------------------
  // q/2^11 lies in (0.5, 2): either q[11] is the leading one, or q[10] is and
  // the exponent drops by one.
  logic signed [6:0] exp_e;
  logic [9:0]        mant_n;

  assign exp_e  = 7'({2'b00, ea_q}) - 7'({2'b00, eb_q})
                + (q_q[11] ? BiasExp : (BiasExp - 7'd1));
  assign mant_n = q_q[11] ? q_q[10:1] : q_q[9:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (a_zero || b_zero) ? StDone : StDivide;
        end
      end
      StDivide: begin
        if (cnt_q == LastStep) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    quotient    = quot_q;
    div_by_zero = dbz_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d    = sign_in;
          ea_d      = float_a[14:10];
          eb_d      = float_b[14:10];
          divisor_d = {1'b1, float_b[9:0]};
          rem_d     = {1'b0, 1'b1, float_a[9:0]};
          q_d       = 12'd0;
          cnt_d     = 4'd0;
          if (b_zero) begin
            // Divisor check wins over a zero dividend: 0/0 also flags
            quot_d = {sign_in, 5'h1F, 10'h000};
            dbz_d  = 1'b1;
          end else if (a_zero) begin
            quot_d = 16'h0000;
            dbz_d  = 1'b0;
          end
        end
      end

      StDivide: begin
        // The remainder stays below twice the divisor, so the shifted value
        // always fits in 12 bits.
        if (trial_ok) begin
          q_d   = {q_q[10:0], 1'b1};
          rem_d = {trial[10:0], 1'b0};
        end else begin
          q_d   = {q_q[10:0], 1'b0};
          rem_d = {rem_q[10:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
      end

      StNorm: begin
        dbz_d = 1'b0;
        if (exp_e <= 7'sd0) begin
          quot_d = 16'h0000;
        end else if (exp_e >= 7'sd31) begin
          quot_d = {sign_q, 5'h1F, 10'h000};
        end else begin
          quot_d = {sign_q, exp_e[4:0], mant_n};
        end
      end

      StDone: begin
        // Result held stable until taken
      end

      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      ea_q      <= 5'd0;
      eb_q      <= 5'd0;
      divisor_q <= 11'd0;
      rem_q     <= 12'd0;
      q_q       <= 12'd0;
      cnt_q     <= 4'd0;
      quot_q    <= 16'h0000;
      dbz_q     <= 1'b0;
    end else begin
      sign_q    <= sign_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_ieee_div16.sv
// Directed testbench for ieee_div16. Latency is counted in rising edges with the
// accept edge itself as edge 1: normal divides finish after 14 edges, special
// cases after 1.

module tb_ieee_div16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] float_a;
  logic [15:0] float_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic        div_by_zero;

  int errors;
  int checks;

  ieee_div16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .float_a    (float_a),
    .float_b    (float_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, scramble the operands after accept, wait (bounded) for
  // out_valid, capture the result and take it. Inputs change and outputs are
  // sampled on the falling edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic dbz, output int lat);
    @(negedge clk);
    float_a  = a;
    float_b  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    float_a  = 16'hFFFF;
    float_b  = 16'h5555;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q   = quotient;
    dbz = div_by_zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    float_a   = 16'h0000;
    float_b   = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (quotient !== 16'h0000) begin
      errors++; $display("FAIL reset_quotient: got %h expected 0000", quotient);
    end
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vq [4];
    logic [15:0] q;
    logic        dbz;
    int          lat;
    va = '{16'h4000, 16'h3C00, 16'h4200, 16'hC000};
    vb = '{16'h3C00, 16'h4000, 16'h4000, 16'h3C00};
    vq = '{16'h4000, 16'h3800, 16'h3E00, 16'hC000};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], q, dbz, lat);
      checks++;
      if (q !== vq[i]) begin
        errors++;
        $display("FAIL basic_q %h/%h: got %h expected %h", va[i], vb[i], q, vq[i]);
      end
      checks++;
      if (lat != 14) begin
        errors++;
        $display("FAIL basic_latency %h/%h: got %0d expected 14", va[i], vb[i], lat);
      end
      checks++;
      if (dbz !== 1'b0) begin
        errors++;
        $display("FAIL basic_dbz %h/%h: got %b expected 0", va[i], vb[i], dbz);
      end
    end
  endtask

  task automatic test_truncation();
    logic [15:0] q;
    logic        dbz;
    int          lat;
    // 1/3: q = 0101_0101_0101, leading one in q[10]
    run_op(16'h3C00, 16'h4200, q, dbz, lat);
    checks++;
    if (q !== 16'h3555) begin
      errors++; $display("FAIL trunc_one_third: got %h expected 3555", q);
    end
    // 2/3 -> 0.666 truncated: 0x3955
    run_op(16'h4000, 16'h4200, q, dbz, lat);
    checks++;
    if (q !== 16'h3955) begin
      errors++; $display("FAIL trunc_two_thirds: got %h expected 3955", q);
    end
    // Negative divisor, exponent field 31 taken as a normal value:
    // 7C00 (2^16) / BC00 (-1) -> exp 31 overflow -> FC00
    run_op(16'h7C00, 16'hBC00, q, dbz, lat);
    checks++;
    if (q !== 16'hFC00) begin
      errors++; $display("FAIL exp31_overflow: got %h expected FC00", q);
    end
  endtask

  task automatic test_specials();
    logic [15:0] q;
    logic        dbz;
    int          lat;
    run_op(16'h3C00, 16'h0000, q, dbz, lat);
    checks++;
    if (q !== 16'h7C00 || dbz !== 1'b1) begin
      errors++; $display("FAIL div_zero: got %h/%b expected 7C00/1", q, dbz);
    end
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL div_zero_latency: got %0d expected 1", lat);
    end
    // Negative dividend with zero divisor keeps the sign
    run_op(16'hC000, 16'h0000, q, dbz, lat);
    checks++;
    if (q !== 16'hFC00 || dbz !== 1'b1) begin
      errors++; $display("FAIL div_zero_neg: got %h/%b expected FC00/1", q, dbz);
    end
    run_op(16'h0000, 16'h4000, q, dbz, lat);
    checks++;
    if (q !== 16'h0000 || dbz !== 1'b0) begin
      errors++; $display("FAIL zero_dividend: got %h/%b expected 0000/0", q, dbz);
    end
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL zero_dividend_latency: got %0d expected 1", lat);
    end
    run_op(16'h7BFF, 16'h0400, q, dbz, lat);
    checks++;
    if (q !== 16'h7C00 || dbz !== 1'b0) begin
      errors++; $display("FAIL overflow: got %h/%b expected 7C00/0", q, dbz);
    end
    run_op(16'h0400, 16'h7BFF, q, dbz, lat);
    checks++;
    if (q !== 16'h0000 || dbz !== 1'b0) begin
      errors++; $display("FAIL underflow: got %h/%b expected 0000/0", q, dbz);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q;
    logic        dbz;
    int          lat;
    @(negedge clk);
    float_a  = 16'h4200;
    float_b  = 16'h4000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 14) begin
      errors++; $display("FAIL bp_latency: got %0d expected 14", lat);
    end
    // Hold off the consumer while presenting new operands, which must be ignored
    float_a  = 16'h3C00;
    float_b  = 16'h4200;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || quotient !== 16'h3E00 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b q=%h r=%b expected v=1 q=3E00 r=0",
                 i, out_valid, quotient, in_ready);
      end
    end
    // Take the result with in_valid still high: the new operands must not be
    // accepted on this same edge.
    float_a   = 16'h3C00;
    float_b   = 16'h0000;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    // in_valid still high: accepted now, divide by zero finishes in one edge
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || quotient !== 16'h7C00 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_release: got v=%b q=%h z=%b expected v=1 q=7C00 z=1",
               out_valid, quotient, div_by_zero);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // Back-to-back normal operations
    run_op(16'h3C00, 16'h4000, q, dbz, lat);
    checks++;
    if (q !== 16'h3800 || dbz !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got %h/%b expected 3800/0", q, dbz);
    end
    run_op(16'hC000, 16'h3C00, q, dbz, lat);
    checks++;
    if (q !== 16'hC000 || lat != 14) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d expected C000 lat 14", q, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] q;
    logic        dbz;
    int          lat;
    int          seen;
    // Leave a non-zero result in the output register first
    run_op(16'h3C00, 16'h0000, q, dbz, lat);
    @(negedge clk);
    float_a  = 16'h4000;
    float_b  = 16'h3C00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    checks++;
    if (quotient !== 16'h0000 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h/%b expected 0000/0", quotient, div_by_zero);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", seen);
    end
    run_op(16'h4200, 16'h4000, q, dbz, lat);
    checks++;
    if (q !== 16'h3E00 || lat != 14) begin
      errors++; $display("FAIL midrst_next_op: got %h lat %0d expected 3E00 lat 14", q, lat);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_truncation();
    test_specials();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
